// File: rtl/mem_pkg.sv
// Shared definitions for the data memory unit: RV32I load/store funct3 codes and FSM encoding.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_half(input logic [2:0] f3);
        return f3[1:0] == F3_H[1:0];
    endfunction

    // Codes 010 and 011 (and their unsigned forms) all move a full word.
    function automatic logic is_word(input logic [2:0] f3);
        return (f3[1:0] == F3_W[1:0]) || (f3[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[8*byte_off +: 8];
        lane_h = byte_off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'h0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'h0, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle RV32I load/store unit with internal word memory and a stall handshake to the core.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] data_mem_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] a_q;
    logic [2:0]  f3_q;
    logic [31:0] wd_q;
    logic        wr_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          access;
    logic          in_range;
    logic          wr_en;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   ld_data;
    logic [3:0]    be;
    logic [31:0]   wlane;

    always_comb begin
        misaligned = (mem_read | mem_write) &
                     ((is_half(funct3) & addr[0]) | (is_word(funct3) & (addr[1:0] != 2'b00)));
        req        = (mem_read | mem_write) & ~misaligned;
        stall      = ((state == IDLE) & req) | (state == BUSY);
    end

    // The array access happens on the edge that ends the last BUSY cycle.
    always_comb begin
        access   = (state == BUSY) && (cnt <= 4'd1);
        in_range = {2'b00, a_q[31:2]} < 32'(DEPTH_WORDS);
        idx      = a_q[AW+1:2];
        wr_en    = access && wr_q && in_range && !rst;
        rd_word  = mem[idx];
    end

    always_comb begin
        be    = 4'b1111;
        wlane = wd_q;
        if (f3_q[1:0] == F3_B[1:0]) begin
            be    = 4'b0001 << a_q[1:0];
            wlane = {4{wd_q[7:0]}};
        end else if (is_half(f3_q)) begin
            be    = a_q[1] ? 4'b1100 : 4'b0011;
            wlane = {2{wd_q[15:0]}};
        end
    end

    load_align u_load_align (
        .word     (rd_word),
        .byte_off (a_q[1:0]),
        .funct3   (f3_q),
        .result   (ld_data)
    );

    // Array is not reset; a reset asserted during BUSY suppresses the write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            a_q           <= 32'h0;
            f3_q          <= 3'b000;
            wd_q          <= 32'h0;
            wr_q          <= 1'b0;
            data_mem_data <= 32'h0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        a_q   <= addr;
                        f3_q  <= funct3;
                        wd_q  <= wdata;
                        wr_q  <= mem_write;
                        cnt   <= 4'(LATENCY);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!access) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!wr_q) data_mem_data <= in_range ? ld_data : 32'h0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed self-checking bench for data_mem_unit: handshake timing, lane writes, load extension, faults.
module tb_data_mem_unit;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data_mem_data;
    logic        stall;
    logic        done;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    data_mem_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .data_mem_data (data_mem_data),
        .stall         (stall),
        .done          (done),
        .misaligned    (misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access: request in IDLE, LAT BUSY cycles, then the DONE cycle.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_data);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(negedge clk);
        check({tag, " stall c0"}, 32'(stall), 32'd1);
        check({tag, " done c0"}, 32'(done), 32'd0);
        check({tag, " misaligned"}, 32'(misaligned), 32'd0);
        @(posedge clk) #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int c = 1; c <= int'(LAT); c++) begin
            @(negedge clk);
            check({tag, " stall busy"}, 32'(stall), 32'd1);
            check({tag, " done busy"}, 32'(done), 32'd0);
            @(posedge clk) #1;
        end
        @(negedge clk);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " stall done"}, 32'(stall), 32'd0);
        check({tag, " data"}, data_mem_data, exp_data);
        @(posedge clk) #1;
    endtask

    // Hold a misaligned request for several cycles; nothing may happen.
    task automatic misaligned_req(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] held);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = 32'h5A5A_5A5A;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check({tag, " misaligned"}, 32'(misaligned), 32'd1);
            check({tag, " stall"}, 32'(stall), 32'd0);
            check({tag, " done"}, 32'(done), 32'd0);
            @(posedge clk) #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check({tag, " done after"}, 32'(done), 32'd0);
        check({tag, " data held"}, data_mem_data, held);
        @(posedge clk) #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset data", data_mem_data, 32'h0);
        check("reset done", 32'(done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        @(posedge clk) #1;

        access("SW 0x10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0);
        access("LB 0x13", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE);
        access("LBU 0x13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE);
        access("LH 0x12", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD);
        access("LHU 0x10", 1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF);
        access("LW 0x10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF);

        access("SB 0x11", 1'b0, 1'b1, 3'b000, 32'h11, 32'h0000_00AA, 32'hDEAD_BEEF);
        access("LW after SB", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_AAEF);
        access("SH 0x12", 1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'hDEAD_AAEF);
        access("LW after SH", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AAEF);
        access("LB 0x11", 1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFAA);

        misaligned_req("LW 0x12", 1'b1, 1'b0, 3'b010, 32'h12, 32'hFFFF_FFAA);
        misaligned_req("SH 0x13", 1'b0, 1'b1, 3'b001, 32'h13, 32'hFFFF_FFAA);
        access("LW after misaligned", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AAEF);

        access("SW 0x20", 1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 32'h1234_AAEF);

        // Store aborted by reset while BUSY.
        mem_write = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h20;
        wdata     = 32'h0000_0055;
        @(negedge clk);
        check("abort stall c0", 32'(stall), 32'd1);
        @(posedge clk) #1;
        mem_write = 1'b0;
        @(negedge clk);
        check("abort stall busy", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("abort data", data_mem_data, 32'h0);
        check("abort stall", 32'(stall), 32'd0);
        check("abort done", 32'(done), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort idle stall", 32'(stall), 32'd0);
            check("abort idle done", 32'(done), 32'd0);
            @(posedge clk) #1;
        end
        access("LW 0x20 after abort", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFE_F00D);

        access("SW out of range", 1'b0, 1'b1, 3'b010, 32'(DEPTH * 4 + 32'h10), 32'h0000_0BAD, 32'hCAFE_F00D);
        access("LW out of range", 1'b1, 1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 32'h0);
        access("LW no alias", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_AAEF);

        access("RD+WR is store", 1'b1, 1'b1, 3'b010, 32'h24, 32'h0F0F_0F0F, 32'h1234_AAEF);
        access("LW 0x24", 1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 32'h0F0F_0F0F);
        access("LHU 0x26", 1'b1, 1'b0, 3'b101, 32'h26, 32'h0, 32'h0000_0F0F);

        @(negedge clk);
        check("final done low", 32'(done), 32'd0);
        check("final stall low", 32'(stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
